// File: rtl/turbo_enc_pkg.sv
// Shared types and default parameters for the turbo encoder control slice.
package turbo_enc_pkg;

  localparam int unsigned LEN_W_DEF    = 14;
  localparam int unsigned TAIL_LEN_DEF = 3;
  localparam int unsigned MIN_LEN_DEF  = 8;
  localparam int unsigned MAX_LEN_DEF  = 6144;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENCTERM = 3'd1,
    ST_TERM    = 3'd2,
    ST_ENCODE  = 3'd3,
    ST_ENCMOD  = 3'd4
  } state_e;

endpackage

// File: rtl/turbo_enc_ctrl_if.sv
// Framer/encoder-control bundle. blk_cnt exists only when BLK_CNT_EN is defined.
interface turbo_enc_ctrl_if #(parameter int unsigned LEN_W = 14);
  logic             start;
  logic [LEN_W-1:0] blk_len;
  logic             ready;
  logic             enc_en;
  logic             trl_en;
  logic             sel_tail;
  logic             enc_clr;
  logic             trl_clr;
  logic             blk_done;
  logic             len_err;
  logic [LEN_W-1:0] pos;
  logic [2:0]       state;
`ifdef BLK_CNT_EN
  logic [15:0]      blk_cnt;

  modport master (output start, blk_len,
                  input  ready, enc_en, trl_en, sel_tail, enc_clr, trl_clr,
                         blk_done, len_err, pos, state, blk_cnt);
  modport slave  (input  start, blk_len,
                  output ready, enc_en, trl_en, sel_tail, enc_clr, trl_clr,
                         blk_done, len_err, pos, state, blk_cnt);
`else
  modport master (output start, blk_len,
                  input  ready, enc_en, trl_en, sel_tail, enc_clr, trl_clr,
                         blk_done, len_err, pos, state);
  modport slave  (input  start, blk_len,
                  output ready, enc_en, trl_en, sel_tail, enc_clr, trl_clr,
                         blk_done, len_err, pos, state);
`endif
endinterface

// File: rtl/turbo_len_check.sv
// Block-length legality compare, shared with the interleaver address generator.
module turbo_len_check
  import turbo_enc_pkg::*;
#(
  parameter int unsigned LEN_W   = LEN_W_DEF,
  parameter int unsigned MIN_LEN = MIN_LEN_DEF,
  parameter int unsigned MAX_LEN = MAX_LEN_DEF
) (
  input  logic [LEN_W-1:0] len_i,
  output logic             legal_o
);

  assign legal_o = (len_i >= LEN_W'(MIN_LEN)) && (len_i <= LEN_W'(MAX_LEN));

endmodule

// File: rtl/turbo_enc_ctrl.sv
// Turbo encoder control FSM: block encode, trellis tail, and tail/next-block overlap.
// Optional macro BLK_CNT_EN adds a wrapping count of completed blocks.
module turbo_enc_ctrl
  import turbo_enc_pkg::*;
#(
  parameter int unsigned LEN_W    = LEN_W_DEF,
  parameter int unsigned TAIL_LEN = TAIL_LEN_DEF,
  parameter int unsigned MIN_LEN  = MIN_LEN_DEF,
  parameter int unsigned MAX_LEN  = MAX_LEN_DEF
) (
  input logic             clk,
  input logic             reset,
  turbo_enc_ctrl_if.slave bus
);

  localparam logic [LEN_W-1:0] ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] TAIL = LEN_W'(TAIL_LEN);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] pos_q, pos_d, len_q, len_d;
  logic enc_en_q, enc_en_d, trl_en_q, trl_en_d, sel_tail_q, sel_tail_d;
  logic enc_clr_q, enc_clr_d, trl_clr_q, trl_clr_d;
  logic blk_done_q, blk_done_d, len_err_q, len_err_d, ready_q, ready_d;
  logic legal_s, last_s, take_s;

  turbo_len_check #(.LEN_W(LEN_W), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) u_len_check (
    .len_i   (bus.blk_len),
    .legal_o (legal_s)
  );

  assign last_s = (pos_q == (len_q - ONE));
  assign take_s = bus.start && legal_s;

  // Next-state and next-output computation
  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    len_d      = len_q;
    enc_en_d   = enc_en_q;
    sel_tail_d = sel_tail_q;
    enc_clr_d  = enc_clr_q;
    trl_clr_d  = trl_clr_q;
    blk_done_d = 1'b0;
    len_err_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (take_s) begin
          len_d     = bus.blk_len;
          pos_d     = '0;
          enc_en_d  = 1'b1;
          enc_clr_d = 1'b0;
          trl_clr_d = 1'b0;
          state_d   = ST_ENCODE;
        end else begin
          len_err_d = bus.start;
        end
      end
      ST_ENCODE, ST_ENCMOD: begin
        trl_clr_d = 1'b0;
        if (last_s) begin
          sel_tail_d = 1'b1;
          enc_clr_d  = 1'b1;
          pos_d      = '0;
          // A legal start here overlaps the new block's data with this tail
          if (take_s) begin
            len_d   = bus.blk_len;
            state_d = ST_ENCTERM;
          end else begin
            len_err_d = bus.start;
            enc_en_d  = 1'b0;
            state_d   = ST_TERM;
          end
        end else begin
          pos_d = pos_q + ONE;
        end
      end
      ST_TERM: begin
        enc_clr_d = 1'b0;
        if (pos_q == TAIL) begin
          sel_tail_d = 1'b0;
          trl_clr_d  = 1'b1;
          blk_done_d = 1'b1;
          pos_d      = '0;
          state_d    = ST_IDLE;
        end else begin
          pos_d = pos_q + ONE;
        end
      end
      ST_ENCTERM: begin
        enc_clr_d = 1'b0;
        pos_d     = pos_q + ONE;
        if (pos_q == TAIL) begin
          sel_tail_d = 1'b0;
          trl_clr_d  = 1'b1;
          blk_done_d = 1'b1;
          state_d    = ST_ENCMOD;
        end else begin
          state_d = ST_ENCTERM;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        pos_d      = '0;
        enc_en_d   = 1'b0;
        sel_tail_d = 1'b0;
      end
    endcase
    // trl_en and ready are looked up from next state so they stay registered
    trl_en_d = enc_en_d && ((state_d == ST_ENCODE) || (state_d == ST_ENCMOD)) &&
               (pos_d == (len_d - ONE));
    ready_d  = (state_d == ST_IDLE) ||
               (((state_d == ST_ENCODE) || (state_d == ST_ENCMOD)) && (pos_d == (len_d - ONE)));
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pos_q      <= '0;
      len_q      <= '0;
      enc_en_q   <= 1'b0;
      trl_en_q   <= 1'b0;
      sel_tail_q <= 1'b0;
      enc_clr_q  <= 1'b1;
      trl_clr_q  <= 1'b1;
      blk_done_q <= 1'b0;
      len_err_q  <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      len_q      <= len_d;
      enc_en_q   <= enc_en_d;
      trl_en_q   <= trl_en_d;
      sel_tail_q <= sel_tail_d;
      enc_clr_q  <= enc_clr_d;
      trl_clr_q  <= trl_clr_d;
      blk_done_q <= blk_done_d;
      len_err_q  <= len_err_d;
      ready_q    <= ready_d;
    end
  end

  assign bus.ready    = ready_q;
  assign bus.enc_en   = enc_en_q;
  assign bus.trl_en   = trl_en_q;
  assign bus.sel_tail = sel_tail_q;
  assign bus.enc_clr  = enc_clr_q;
  assign bus.trl_clr  = trl_clr_q;
  assign bus.blk_done = blk_done_q;
  assign bus.len_err  = len_err_q;
  assign bus.pos      = pos_q;
  assign bus.state    = state_q;

`ifdef BLK_CNT_EN
  logic [15:0] blk_cnt_q;

  // Completed-block counter, wraps naturally at 16 bits
  always_ff @(posedge clk) begin
    if (reset) begin
      blk_cnt_q <= 16'd0;
    end else if (blk_done_d) begin
      blk_cnt_q <= blk_cnt_q + 16'd1;
    end else begin
      blk_cnt_q <= blk_cnt_q;
    end
  end

  assign bus.blk_cnt = blk_cnt_q;
`endif

endmodule
